// File: rtl/dct_coeff_sequencer.sv
// dct_coeff_sequencer
//   Sequences one 8x8 2-D DCT block through a per-(k1,k2) cosine LUT bank and a
//   single multiply-accumulator. For each of the 64 output coefficients (k1,k2)
//   it reads all 64 pixels (n1,n2) from a synchronous block RAM, accumulates
//   pixel*cos_term, then presents the scaled, saturated coefficient on a
//   valid/ready port. Coefficients leave in row-major {k1,k2} order.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a block (only honoured while idle)
//   busy                  high whenever a block is in progress
//   pix_addr, pix_rd      pixel RAM address {n1,n2} and read enable
//   pix_data              RAM read data, one cycle after pix_rd
//   lut_k1, lut_k2        LUT-bank select (frequency of current coefficient)
//   lut_n1, lut_n2        LUT index, aligned with pix_data
//   cos_term              signed LUT output (FRAC_BITS fractional bits)
//   coef_valid/ready      coefficient handshake
//   coef_data, coef_idx   signed coefficient and its {k1,k2}
//   done                  one-cycle pulse after the last coefficient is taken
module dct_coeff_sequencer #(
    parameter int PIX_W       = 8,
    parameter int ACC_W       = 32,
    parameter int COEF_W      = 16,
    parameter int FRAC_BITS   = 8,
    parameter int LEVEL_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic [5:0]               pix_addr,
    output logic                     pix_rd,
    input  logic [PIX_W-1:0]         pix_data,
    output logic [2:0]               lut_k1,
    output logic [2:0]               lut_k2,
    output logic [2:0]               lut_n1,
    output logic [2:0]               lut_n2,
    input  logic signed [31:0]       cos_term,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [COEF_W-1:0] coef_data,
    output logic [5:0]               coef_idx,
    output logic                     done
);

    localparam int PROD_W = PIX_W + 33;
    localparam logic signed [ACC_W-1:0] COEF_MAX =
        {{(ACC_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] COEF_MIN =
        {{(ACC_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                   state, state_nx;
    logic [5:0]               n_cnt;      // pixel {n1,n2} being issued
    logic [5:0]               k_cnt;      // coefficient {k1,k2} being built
    logic                     vld_p1;     // pix_rd delayed to line up with pix_data
    logic [5:0]               n_p1;       // pix_addr delayed, drives the LUT index
    logic signed [ACC_W-1:0]  acc;
    logic                     done_p1;
    logic                     accept;
    logic                     last_coef;

    // Level-shifted (or zero-extended) pixel times cos_term, truncated to ACC_W.
    function automatic logic signed [ACC_W-1:0] mac_product(
        input logic [PIX_W-1:0]   pix,
        input logic signed [31:0] cterm
    );
        logic signed [PIX_W:0]    p;
        logic signed [PROD_W-1:0] prod;
        if (LEVEL_SHIFT != 0)
            p = $signed({1'b0, pix}) - $signed({2'b01, {(PIX_W-1){1'b0}}});
        else
            p = $signed({1'b0, pix});
        prod = PROD_W'(p) * PROD_W'(cterm);
        return prod[ACC_W-1:0];
    endfunction

    // Floor-scale the accumulator and clamp into the signed COEF_W range.
    function automatic logic signed [COEF_W-1:0] sat_coef(
        input logic signed [ACC_W-1:0] a
    );
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_BITS;
        if (s > COEF_MAX)
            return {1'b0, {(COEF_W-1){1'b1}}};
        else if (s < COEF_MIN)
            return {1'b1, {(COEF_W-1){1'b0}}};
        else
            return s[COEF_W-1:0];
    endfunction

    assign accept    = (state == OUT) && coef_ready;
    assign last_coef = (k_cnt == 6'd63);

    always_comb begin
        state_nx   = state;
        busy       = (state != IDLE);
        pix_rd     = (state == RUN);
        pix_addr   = 6'd0;
        coef_valid = (state == OUT);
        coef_data  = '0;
        coef_idx   = 6'd0;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN: begin
                pix_addr = n_cnt;
                if (n_cnt == 6'd63) state_nx = DRAIN;
            end
            DRAIN: state_nx = OUT;
            OUT: begin
                coef_data = sat_coef(acc);
                coef_idx  = k_cnt;
                if (accept) state_nx = last_coef ? IDLE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign lut_k1 = k_cnt[5:3];
    assign lut_k2 = k_cnt[2:0];
    assign lut_n1 = n_p1[5:3];
    assign lut_n2 = n_p1[2:0];
    assign done   = done_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_cnt   <= 6'd0;
            k_cnt   <= 6'd0;
            vld_p1  <= 1'b0;
            n_p1    <= 6'd0;
            acc     <= '0;
            done_p1 <= 1'b0;
        end else begin
            state   <= state_nx;
            done_p1 <= accept && last_coef;
            // stage p0 -> p1: read issued, RAM data and LUT index arrive together
            vld_p1  <= pix_rd;
            n_p1    <= pix_addr;
            if (state == RUN)
                n_cnt <= n_cnt + 6'd1;
            if (accept) begin
                k_cnt <= k_cnt + 6'd1;
                n_cnt <= 6'd0;
            end
            // stage p1 -> acc: the final pixel lands on the DRAIN edge
            if (state_nx == RUN && state != RUN)
                acc <= '0;
            else if (vld_p1)
                acc <= acc + mac_product(pix_data, cos_term);
        end
    end

endmodule
